// File: rtl/smg_bcd_display.sv
// Binary-to-BCD converter (double-dabble, one bit per clock) feeding a multiplexed
// active-low seven-segment display with leading-zero blanking and overflow dashes.
module smg_bcd_display #(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    input  logic              blank_en,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        Row_Scan_Sig,
    output logic [DIGITS-1:0] Column_Scan_Sig,
    output logic [1:0]        o_dbg_state
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_bin;
    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    r_disp;
    logic                r_ovf_work;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_idx;

    logic [BCD_W-1:0]    w_adj;
    logic [BCD_W-1:0]    w_bcd_shift;
    logic                w_shift_out;
    logic [BCD_W-1:0]    w_disp_next;
    logic                w_ovf_next;
    logic                w_scan_wrap;
    logic [IDX_W-1:0]    w_idx_next;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_digit;
    logic                w_blank_here;
    logic [7:0]          w_row;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    assign o_dbg_state = r_state;

    // Double-dabble step: add 3 to every digit >= 5, then shift BCD||binary left by one.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
    assign w_shift_out = w_adj[BCD_W-1];

    // Handshake: load is a one-cycle request honoured only while busy=0 (IDLE);
    // busy stays high from capture until the commit edge, done pulses on commit.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_disp     <= '0;
            r_ovf_work <= 1'b0;
            r_bit_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin      <= data_in;
                        r_bcd      <= '0;
                        r_ovf_work <= 1'b0;
                        r_bit_cnt  <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd      <= w_bcd_shift;
                    r_bin      <= r_bin << 1;
                    r_ovf_work <= r_ovf_work | w_shift_out;
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_disp   <= r_bcd;
                    overflow <= r_ovf_work;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Segment/select outputs are built from next-state values so both land on the same edge.
    assign w_disp_next = (r_state == S_COMMIT) ? r_bcd : r_disp;
    assign w_ovf_next  = (r_state == S_COMMIT) ? r_ovf_work : overflow;
    assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        w_idx_next = r_idx;
        if (w_scan_wrap) begin
            w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // w_lz[k]: digit k and every digit above it are zero.
    always_comb begin
        w_lz = '0;
        w_lz[DIGITS-1] = (w_disp_next[BCD_W-1 -: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            w_lz[k] = w_lz[k+1] && (w_disp_next[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        w_digit      = w_disp_next[3:0];
        w_blank_here = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (w_idx_next == IDX_W'(k)) begin
                w_digit      = w_disp_next[4*k +: 4];
                w_blank_here = w_lz[k];
            end
        end
        if (w_ovf_next) begin
            w_row = 8'hBF;
        end else if (blank_en && w_blank_here) begin
            w_row = 8'hFF;
        end else begin
            w_row = seg_code(w_digit);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_scan_cnt      <= '0;
            r_idx           <= '0;
            Column_Scan_Sig <= ~(DIGITS'(1));
            Row_Scan_Sig    <= 8'hC0;
        end else begin
            r_scan_cnt      <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
            r_idx           <= w_idx_next;
            Column_Scan_Sig <= ~(DIGITS'(1) << w_idx_next);
            Row_Scan_Sig    <= w_row;
        end
    end

endmodule

// File: tb/tb_smg_bcd_display.sv
// Bench for smg_bcd_display: three parameterisations share stimulus; a decimal
// reference model predicts commit timing, overflow and the scanned segment pattern.
module tb_smg_bcd_display;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              load = 1'b0;
    logic              blank_en = 1'b0;

    logic       busy_a, done_a, ovf_a;
    logic [7:0] row_a;
    logic [5:0] col_a;
    logic [1:0] st_a;
    logic       busy_b, done_b, ovf_b;
    logic [7:0] row_b;
    logic [1:0] col_b;
    logic [1:0] st_b;
    logic       busy_c, done_c, ovf_c;
    logic [7:0] row_c;
    logic [0:0] col_c;
    logic [1:0] st_c;

    always #5 clk = ~clk;

    smg_bcd_display #(.DATA_W(DATA_W), .DIGITS(6), .SCAN_DIV(3)) u_a (
        .CLK(clk), .RST_n(rst_n), .data_in(data_in), .load(load), .blank_en(blank_en),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .Row_Scan_Sig(row_a),
        .Column_Scan_Sig(col_a), .o_dbg_state(st_a));

    smg_bcd_display #(.DATA_W(DATA_W), .DIGITS(2), .SCAN_DIV(4)) u_b (
        .CLK(clk), .RST_n(rst_n), .data_in(data_in), .load(load), .blank_en(blank_en),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .Row_Scan_Sig(row_b),
        .Column_Scan_Sig(col_b), .o_dbg_state(st_b));

    smg_bcd_display #(.DATA_W(DATA_W), .DIGITS(1), .SCAN_DIV(2)) u_c (
        .CLK(clk), .RST_n(rst_n), .data_in(data_in), .load(load), .blank_en(blank_en),
        .busy(busy_c), .done(done_c), .overflow(ovf_c), .Row_Scan_Sig(row_c),
        .Column_Scan_Sig(col_c), .o_dbg_state(st_c));

    // Rising edges seen since reset was released.
    int n_edges = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    logic [DATA_W-1:0] exp_q[$];
    int                due_q[$];
    int                disp_val = 0;
    int                last_commit = -1;
    int                n_checks = 0;
    int                n_pass = 0;
    bit                mon_on = 1'b1;

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_row(input int digits, input int v, input bit blank, input int k);
        if (v > pow10(digits) - 1) return 8'hBF;
        if (blank && k >= 1 && v < pow10(k)) return 8'hFF;
        return seg_of((v / pow10(k)) % 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic sample_inst(input string tag, input int digits, input int sdiv,
                               input bit eb, input bit ed,
                               input logic b, input logic d, input logic o,
                               input logic [7:0] row, input logic [7:0] col);
        int         idx;
        logic [7:0] ecol;
        bit         eovf;
        idx  = (n_edges / sdiv) % digits;
        ecol = 8'((~(32'd1 << idx)) & ((32'd1 << digits) - 32'd1));
        eovf = (disp_val > pow10(digits) - 1);
        check({tag, ".busy"}, 32'(b), 32'(eb));
        check({tag, ".done"}, 32'(d), 32'(ed));
        check({tag, ".overflow"}, 32'(o), 32'(eovf));
        check({tag, ".column"}, 32'(col), 32'(ecol));
        check({tag, ".row"}, 32'(row), 32'(exp_row(digits, disp_val, blank_en, idx)));
    endtask

    // Monitor: pops the scoreboard on the commit cycle and checks every output each cycle.
    initial begin
        forever begin
            bit ed;
            bit eb;
            @(posedge clk);
            #1;
            if (mon_on) begin
                ed = 1'b0;
                if (due_q.size() != 0 && due_q[0] == n_edges) begin
                    ed = 1'b1;
                    disp_val = int'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
                eb = (due_q.size() != 0);
                sample_inst("a", 6, 3, eb, ed, busy_a, done_a, ovf_a, row_a, {2'b00, col_a});
                sample_inst("b", 2, 4, eb, ed, busy_b, done_b, ovf_b, row_b, {6'b0, col_b});
                sample_inst("c", 1, 2, eb, ed, busy_c, done_c, ovf_c, row_c, {7'b0, col_c});
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A load is taken only if its edge falls after the previous conversion's commit edge.
    task automatic issue_load(input logic [DATA_W-1:0] v);
        int e;
        @(negedge clk);
        data_in = v;
        load    = 1'b1;
        e = n_edges + 1;
        if (e > last_commit) begin
            exp_q.push_back(v);
            due_q.push_back(e + DATA_W + 1);
            last_commit = e + DATA_W + 1;
        end
        @(negedge clk);
        load    = 1'b0;
        data_in = DATA_W'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        disp_val    = 0;
        last_commit = -1;
        #1;
        check("rst.busy_a", 32'(busy_a), 32'd0);
        check("rst.done_a", 32'(done_a), 32'd0);
        check("rst.row_a", 32'(row_a), 32'hC0);
        check("rst.col_a", 32'(col_a), 32'h3E);
        check("rst.col_c", 32'(col_c), 32'd0);
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [DATA_W-1:0] edge_vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};

    initial begin
        wait_cycles(3);
        rst_n = 1'b1;

        blank_en = 1'b1;
        issue_load(8'd75);
        wait_cycles(30);
        blank_en = 1'b0;
        issue_load(8'd255);
        wait_cycles(30);
        issue_load(8'd100);
        wait_cycles(20);
        issue_load(8'd99);
        wait_cycles(20);

        blank_en = 1'b1;
        issue_load(8'd123);
        wait_cycles(1);
        issue_load(8'd45);
        wait_cycles(25);

        issue_load(8'd75);
        wait_cycles(20);
        issue_load(8'd200);
        wait_cycles(2);
        do_reset(2);
        wait_cycles(25);

        for (int i = 0; i < 40; i++) begin
            logic [DATA_W-1:0] v;
            blank_en = 1'($urandom_range(0, 1));
            wait_cycles($urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) v = edge_vals[$urandom_range(0, 5)];
            else                           v = DATA_W'($urandom_range(0, 255));
            issue_load(v);
        end
        wait_cycles(30);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/smg_bcd_display.md
SMG_BCD_DISPLAY -- requirements
Module: smg_bcd_display

Interface
REQ-001 SHALL have parameter DATA_W, default 8: binary input width, legal 1..32.
REQ-002 SHALL have parameter DIGITS, default 6: number of display digits, legal 1..8.
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is lit, legal >=2.
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_in  input  DATA_W  unsigned binary value to display.
REQ-007 SHALL have port load  input  1  one-cycle strobe requesting conversion of data_in.
REQ-008 SHALL have port blank_en  input  1  1 = blank leading zeros.
REQ-009 SHALL have port busy  output  1  conversion in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the new value is committed.
REQ-011 SHALL have port overflow  output  1  committed value exceeds 10^DIGITS-1.
REQ-012 SHALL have port Row_Scan_Sig  output  8  segment drive, active-low, bit7=dp, bits6..0=g..a.
REQ-013 SHALL have port Column_Scan_Sig  output  DIGITS  digit select, active-low, bit i = digit i, digit 0 = units.

Function
REQ-014 SHALL use FSM IDLE -> SHIFT -> COMMIT -> IDLE.
REQ-015 In IDLE, load=1 at edge E0 SHALL capture data_in, clear the BCD work register and overflow-work flag, set busy, and enter SHIFT.
REQ-016 SHIFT SHALL run exactly DATA_W cycles (edges E1..E_DATA_W), MSB first, double-dabble: each 4-bit BCD digit >=5 gets +3, then the BCD||binary register shifts left 1.
REQ-017 Any 1 shifted out of the top BCD digit SHALL set the sticky overflow-work flag.
REQ-018 COMMIT at edge E_(DATA_W+1) SHALL copy BCD digits to the display register, copy the flag to overflow, pulse done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-019 busy SHALL be 1 for exactly DATA_W+1 cycles per conversion.
REQ-020 load while busy=1 SHALL be ignored; no queuing.
REQ-021 The display register SHALL change only at COMMIT; no partial values are ever displayed.
REQ-022 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance 0,1..DIGITS-1,0.
REQ-023 Column_Scan_Sig SHALL be registered, with exactly one bit low = current digit index.
REQ-024 Row_Scan_Sig SHALL be registered from the same edge as Column_Scan_Sig, so select and segments never mismatch.
REQ-025 Segment codes SHALL be 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 blank:FF dash:BF (dp always off).
REQ-026 With blank_en=1, digit k>=1 SHALL show FF when it and all higher digits are 0; digit 0 is never blanked.
REQ-027 blank_en SHALL be applied live, not latched at COMMIT.
REQ-028 When overflow=1, every digit SHALL show BF, regardless of blank_en.
REQ-029 Scanning SHALL continue uninterrupted during conversion; the old value stays displayed until COMMIT.
REQ-030 DIGITS=1 SHALL hold Column_Scan_Sig at 0 constantly.

Reset
REQ-031 RST_n=0 SHALL immediately force: FSM IDLE, busy=0, done=0, overflow=0, display register all 0, scan counter 0, digit index 0.
REQ-032 Under reset, Column_Scan_Sig SHALL be ~1 (digit 0 selected) and Row_Scan_Sig SHALL be C0.
REQ-033 Reset mid-conversion SHALL abort the conversion with no COMMIT and no done pulse; the display SHALL show 0.
REQ-034 After RST_n rises, the first load SHALL be accepted on the first rising edge.

Verification
REQ-035 Defaults, data_in=75, load pulse, blank_en=1 -> busy for 9 cycles, one done pulse, overflow=0; digit0 Row=92, digit1 Row=F8, digits2..5 Row=FF.
REQ-036 Defaults, data_in=255, blank_en=0 -> digits show 5,5,2,0,0,0 (92,92,A4,C0,C0,C0).
REQ-037 DIGITS=2, data_in=100 -> overflow=1, both digits BF; a following load of 99 -> overflow=0, digits 90,90.
REQ-038 SCAN_DIV=4, DIGITS=3 -> each select held 4 cycles, order 110,101,011, then 110 again; Row matches select every cycle.
REQ-039 load re-pulsed at busy cycle 3 with a different value -> ignored; the first value is committed; exactly one done pulse.
REQ-040 RST_n low at busy cycle 4 after a committed 75 -> busy=0 at once, no done pulse, display shows C0 on digit 0 with blanking.
